// File: rtl/usb2_ep_buf.sv
// usb2_ep_buf: multi-buffer endpoint packet store with commit/abort on fill side and in-order release on read side
module usb2_ep_buf #(
    parameter int DATA_W  = 8,
    parameter int BUF_AW  = 9,
    parameter int NUM_BUF = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_we,
    input  logic [DATA_W-1:0] wr_dat_w,
    input  logic              wr_commit,
    input  logic              wr_abort,
    output logic              wr_ready,
    output logic              wr_ovf,
    output logic              wr_drop,
    output logic              rd_valid,
    output logic [BUF_AW:0]   rd_len,
    input  logic [BUF_AW-1:0] rd_adr,
    output logic [DATA_W-1:0] rd_dat_r,
    input  logic              rd_release
);
    localparam int IW = $clog2(NUM_BUF);
    localparam logic [IW:0] FULL = (IW+1)'(NUM_BUF);
    logic [DATA_W-1:0] mem [NUM_BUF*(2**BUF_AW)];
    logic [BUF_AW:0] len_q [NUM_BUF];
    logic [IW-1:0] wr_idx, rd_idx;
    logic [IW:0] cnt;
    logic [BUF_AW:0] wr_len;
    logic [IW+BUF_AW-1:0] rd_adr_q;
    logic accept, ovf_now, commit_ok, drop, release_ok, end_pkt;
    always_comb begin
        wr_ready   = cnt != FULL;
        rd_valid   = cnt != '0;
        accept     = wr_we && wr_ready && !wr_len[BUF_AW];
        ovf_now    = wr_ovf || (wr_we && !accept);
        commit_ok  = wr_commit && !wr_abort && wr_ready && !ovf_now;
        drop       = wr_commit && !wr_abort && ovf_now;
        release_ok = rd_release && rd_valid;
        end_pkt    = wr_abort || commit_ok || drop;
        rd_len     = rd_valid ? len_q[rd_idx] : '0;
        rd_dat_r   = mem[rd_adr_q];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            cnt      <= '0;
            wr_len   <= '0;
            wr_ovf   <= 1'b0;
            wr_drop  <= 1'b0;
            rd_adr_q <= '0;
        end else begin
            wr_idx   <= wr_idx + IW'(commit_ok);
            rd_idx   <= rd_idx + IW'(release_ok);
            cnt      <= cnt + (IW+1)'(commit_ok) - (IW+1)'(release_ok);
            wr_len   <= end_pkt ? '0 : wr_len + (BUF_AW+1)'(accept);
            wr_ovf   <= !end_pkt && ovf_now;
            wr_drop  <= drop;
            rd_adr_q <= {rd_idx, rd_adr};
        end
    end
    always_ff @(posedge clk) begin
        if (accept && !rst) mem[{wr_idx, wr_len[BUF_AW-1:0]}] <= wr_dat_w;
        if (commit_ok && !rst) len_q[wr_idx] <= wr_len + (BUF_AW+1)'(accept);
    end
endmodule

// File: doc/usb2_ep_buf.md
# usb2_ep_buf

Parametrised multi-buffer endpoint packet store for the USB 2.0 core, single clock domain. The protocol/receive side streams bytes into the current fill buffer and commits or aborts whole packets. The endpoint/transmit side sees committed packets in FIFO order, with length, reads them by random address and releases them. It generalises the fixed 1024x8 endpoint RAM with configurable width and depth, N-deep packet queueing, per-packet length tracking, overflow protection and abort/discard.

## Interface
- DATA_W, 8: data width in bits.
- BUF_AW, 9: address bits per buffer; each buffer holds 2^BUF_AW words.
- NUM_BUF, 2: number of packet buffers; power of two, 2..8. Let IW = log2(NUM_BUF) and MAXLEN = 2^BUF_AW.

- clk  in  1  single clock for the whole block.
- rst  in  1  reset, synchronous, active-high.
- wr_we  in  1  write one word at the internal fill pointer.
- wr_dat_w  in  DATA_W  write data.
- wr_commit  in  1  close the current packet and queue it.
- wr_abort  in  1  discard the current packet.
- wr_ready  out  1  a fill buffer is available.
- wr_ovf  out  1  sticky; the current packet exceeded MAXLEN or was written while not ready.
- wr_drop  out  1  one-cycle pulse; a commit was discarded because wr_ovf was set.
- rd_valid  out  1  at least one committed packet is queued.
- rd_len  out  BUF_AW+1  word count of the head packet; 0 when !rd_valid.
- rd_adr  in  BUF_AW  word address within the head packet.
- rd_dat_r  out  DATA_W  data at the registered {head index, rd_adr}.
- rd_release  in  1  free the head packet.

## Operation
- Storage: NUM_BUF*MAXLEN words, DATA_W wide. Word address = {buffer index (IW bits), offset (BUF_AW bits)}. A length register of BUF_AW+1 bits is held per buffer.
- State:
  - wr_idx, rd_idx: IW bits each; increment modulo NUM_BUF.
  - cnt: committed-buffer count, 0..NUM_BUF.
  - wr_len: BUF_AW+1 bits.
  - wr_ovf flag.
- wr_ready = (cnt != NUM_BUF). rd_valid = (cnt != 0).
- Write, when wr_we is high:
  - wr_ready && wr_len < MAXLEN: mem[{wr_idx, wr_len[BUF_AW-1:0]}] <= wr_dat_w; wr_len++.
  - Otherwise: the word is dropped and wr_ovf <= 1. Memory and wr_len are unchanged.
- End of packet. Priority: rst > wr_abort > wr_commit.
  - Abort: wr_len <= 0, wr_ovf <= 0. Indices and cnt are unchanged.
  - Commit, with wr_ready && !wr_ovf (including the wr_ovf update from a same-cycle wr_we):
    - len[wr_idx] <= wr_len, plus 1 if a same-cycle wr_we word was accepted.
    - wr_idx++, cnt++, wr_len <= 0.
    - A zero-length commit (ZLP) is legal and queues length 0.
  - Commit with wr_ovf (or a same-cycle overflow): behaves as abort and pulses wr_drop.
  - Commit with !wr_ready and no overflow: ignored; wr_len is kept.
- Release: rd_release && rd_valid gives rd_idx++ and cnt--. Release with !rd_valid is ignored.
- Simultaneous accepted commit and release: cnt is unchanged; both indices advance.
- Read:
  - {rd_idx, rd_adr} is registered every cycle; rd_dat_r = mem[registered address].
  - Reads beyond rd_len return stale buffer contents; no error is raised.
- The fill buffer is never a committed buffer, so a write never collides with a read of a valid packet.

## Timing
- Reset values:
  - wr_idx = rd_idx = 0, cnt = 0, wr_len = 0.
  - wr_ready = 1, wr_ovf = 0, wr_drop = 0, rd_valid = 0, rd_len = 0.
  - Registered read address = 0. Memory contents are not cleared.
- Reset mid-operation discards all queued and partial packets on the next edge.
- Status latency:
  - wr_ready, rd_valid and rd_len update the cycle after a commit or release edge. A commit in cycle t gives rd_valid = 1 in t+1.
  - wr_drop is registered: high for exactly the cycle after the discarded commit.
  - wr_ovf is set the cycle after the offending wr_we.
- Read latency: exactly one cycle from rd_adr to rd_dat_r. A release in cycle t makes reads presented in t+1 address the new head.
- Memory write is visible to reads the cycle after it is written, once committed. No write-first bypass is needed.

## Test plan
- Basic packet (defaults): write 0x10..0x13, commit with the last write.
  - Expect rd_valid = 1 and rd_len = 4 next cycle.
  - rd_adr = 0..3 returns 0x10..0x13, each one cycle late.
  - Release gives rd_valid = 0.
- Queue full, NUM_BUF = 2: commit packets of length 3 and 5.
  - Expect wr_ready = 0.
  - A third commit is ignored.
  - Head rd_len = 3; after release rd_len = 5 and wr_ready = 1.
- Overflow: write MAXLEN+1 = 513 words, then commit.
  - Expect wr_ovf = 1 after word 513.
  - wr_drop pulses for one cycle; rd_valid stays 0; wr_ovf clears.
- Abort then ZLP: write 7 words, abort, then commit with no writes.
  - Expect rd_valid = 1 with rd_len = 0.
  - The aborted data never appears as a packet.
- Simultaneous: with one packet queued, assert commit and release in the same cycle.
  - Expect cnt unchanged, rd_valid = 1, and rd_len = the new packet's length.
  - Wrap-around checked over 10 packets with NUM_BUF = 4.
- Reset mid-packet: with 2 queued packets and a partial third, pulse rst.
  - Expect wr_ready = 1, rd_valid = 0, rd_len = 0, wr_ovf = 0.
  - The next packet lands in buffer 0.
